hdmi_linebuf_ctrl: RTL and testbench
====================================

// Module: hdmi_linebuf_ctrl
// PURPOSE
//  Write/read controller for the conv0 four-bank 24-bit line BRAM group. Active pixels are written
//  into one bank while the other three are read out as a 3-row column (oldest line first).
//  The bank rotates at the end of each line. The column output feeds the conv0 window/MAC stage.
//  Sits between the HDMI RX pixel stream and the BRAM bank (drives bram_datain/addr/wren, consumes q0..q3).
// PARAMETERS
//  H_ACTIVE  1920  active pixels per line; write column x counts 0..H_ACTIVE-1
//  ADDR_W    11    BRAM address width
//  DATA_W    24    pixel width (RGB888)
//  READ_LAT  2     BRAM read latency in clk cycles (registered address + registered q)
// PORTS
//  clk          in   1       pixel clock; all logic on posedge
//  reset        in   1       asynchronous, active-low reset
//  vsync        in   1       frame sync; its rising edge starts a new frame
//  de           in   1       data enable; high = valid pixel on pix_data
//  pix_data     in   DATA_W  input pixel
//  bram_datain  out  DATA_W  write data to the bank (shared by all four banks)
//  bramaddr0..3 out  ADDR_W  per-bank address; all four carry the same column x
//  wren0..3     out  1       per-bank write enable; one-hot on bank wsel, or all zero
//  q0..q3       in   DATA_W  bank read data
//  col_top      out  DATA_W  pixel at column x of line n-3
//  col_mid      out  DATA_W  pixel at column x of line n-2
//  col_bot      out  DATA_W  pixel at column x of line n-1
//  col_valid    out  1       col_* and col_x/col_y valid this cycle
//  col_x        out  ADDR_W  column index of col_*
//  col_y        out  11      line index n of the line being written when x was sampled
//  err_ovf      out  1       sticky: de was high with x==H_ACTIVE; cleared by vsync rising or reset
// BEHAVIOUR
//  Reset (reset=0, async): every output 0; wsel=0, x=0, y=0, filled=0, FSM=IDLE.
//  FSM:
//   IDLE  -> LINE on the first de=1 after a vsync rising edge.
//   LINE  -> HBLK when de falls.
//   HBLK  -> LINE when de rises.
//   any   -> IDLE on a vsync rising edge.
//  Vsync rising edge: x=0, y=0, filled=0, wsel=0, err_ovf=0.
//   If de=1 in that same cycle, vsync wins and the pixel is dropped.
//  Write path: de=1 and x<H_ACTIVE in cycle t. At t+1: bram_datain=pixel, bramaddr*=x,
//   wren[wsel]=1, others 0. x then increments.
//   If x==H_ACTIVE with de=1: no write, err_ovf<=1, x holds.
//  End of line (de 1->0):
//   wsel<=wsel+1 mod 4 (3 wraps to 0); x<=0; y<=y+1, saturating at 2047;
//   filled<=min(filled+1,3).
//   A short line (fewer than H_ACTIVE pixels) still rotates the bank; unwritten columns keep stale data.
//  Read path: all banks read at the same x. The three non-write banks are ordered from the
//   wsel captured at t, delayed by READ_LAT+1:
//   top=q[(wsel+1)%4], mid=q[(wsel+2)%4], bot=q[(wsel+3)%4].
//  Latency: pixel on pix_data at cycle t -> col_* registered and valid at t+READ_LAT+2 (4 by default).
//   col_x/col_y are delay-matched to col_*.
//  col_valid = delayed (de accepted and filled==3), i.e. only from line 3 of a frame onward.
//   Deasserts with the same latency when de falls.
//  Reset mid-line: the line is lost; after release, writes wait for the next vsync (IDLE).
// CONFIGURATION
//  LINEBUF_ZEROPAD_EN defined:
//   col_valid asserts from line 0 of each frame.
//   Any row not yet filled reads as 0: filled==0 -> top=mid=bot=0; filled==1 -> top=mid=0;
//   filled==2 -> top=0.
//  Undefined: col_valid requires filled==3 and no zero substitution logic is built.
// TESTING
//  1 Assert reset mid-stream -> all outputs 0 same cycle; wren0..3=0; no writes until the next vsync.
//  2 Frame of 4 lines, 8 px each, pixel={y,x}; default build -> col_valid=0 during lines 0-2;
//    line 3, x=5 -> 4 cycles later col_top=line0 px5, col_mid=line1 px5, col_bot=line2 px5, col_x=5.
//  3 Six lines -> wren one-hot sequence bank 0,1,2,3,0,1; at line 4 col_top=line1 data (wrap correct).
//  4 Drive H_ACTIVE+1 pixels in one line -> last pixel not written; err_ovf=1 until the next vsync rise.
//  5 vsync rise while de=1 at x=3 -> pixel dropped; x=y=0; col_valid stays 0 for 3 lines.
//  6 Build with LINEBUF_ZEROPAD_EN; line 1, x=2 -> col_valid=1, top=mid=0, col_bot=line0 px2.

Source files
------------

// File: rtl/hdmi_linebuf_ctrl_if.sv
// BRAM bus between the conv0 line-buffer controller and its four line banks.
interface hdmi_linebuf_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 24
);
    logic [DATA_W-1:0] bram_datain;
    logic [ADDR_W-1:0] bramaddr0;
    logic [ADDR_W-1:0] bramaddr1;
    logic [ADDR_W-1:0] bramaddr2;
    logic [ADDR_W-1:0] bramaddr3;
    logic              wren0;
    logic              wren1;
    logic              wren2;
    logic              wren3;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] q2;
    logic [DATA_W-1:0] q3;

    modport master (
        output bram_datain, bramaddr0, bramaddr1, bramaddr2, bramaddr3,
        output wren0, wren1, wren2, wren3,
        input  q0, q1, q2, q3
    );

    modport slave (
        input  bram_datain, bramaddr0, bramaddr1, bramaddr2, bramaddr3,
        input  wren0, wren1, wren2, wren3,
        output q0, q1, q2, q3
    );
endinterface

// File: rtl/hdmi_linebuf_ctrl.sv
// Four-bank line buffer controller: writes the current line into one bank, reads the other
// three as a 3-row column. Define LINEBUF_ZEROPAD_EN to emit columns from line 0 with zero rows.
module hdmi_linebuf_ctrl #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned READ_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  de,
    input  logic [DATA_W-1:0]     pix_data,
    hdmi_linebuf_ctrl_if.master   bram,
    output logic [DATA_W-1:0]     col_top,
    output logic [DATA_W-1:0]     col_mid,
    output logic [DATA_W-1:0]     col_bot,
    output logic                  col_valid,
    output logic [ADDR_W-1:0]     col_x,
    output logic [10:0]           col_y,
    output logic                  err_ovf
);
    localparam int unsigned       PIPE = READ_LAT + 1;
    localparam logic [ADDR_W-1:0] XMax = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {StIdle, StLine, StHblk} state_e;

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] x;
        logic [10:0]       y;
        logic [1:0]        wsel;
`ifdef LINEBUF_ZEROPAD_EN
        logic [1:0]        filled;
`endif
    } meta_t;

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic              vsync_q;
    logic [ADDR_W-1:0] x_q, x_d;
    logic [10:0]       y_q, y_d;
    logic [1:0]        wsel_q, wsel_d;
    logic [1:0]        filled_q, filled_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        wren_q, wren_d;
    meta_t             meta_q [PIPE];
    meta_t             meta_in;
    meta_t             meta_out;
    logic [DATA_W-1:0] qv [4];
    logic [DATA_W-1:0] col_top_q, col_top_d;
    logic [DATA_W-1:0] col_mid_q, col_mid_d;
    logic [DATA_W-1:0] col_bot_q, col_bot_d;
    logic              col_valid_q, col_valid_d;
    logic [ADDR_W-1:0] col_x_q, col_x_d;
    logic [10:0]       col_y_q, col_y_d;
    logic              vs_rise;
    logic              accept_en;
    logic              col_ok;

    assign vs_rise   = vsync & ~vsync_q;
    // After reset nothing is written until a vsync rise arms the frame.
    assign accept_en = (state_q != StIdle) | armed_q;

`ifdef LINEBUF_ZEROPAD_EN
    assign col_ok = 1'b1;
`else
    assign col_ok = (filled_q == 2'd3);
`endif

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        x_d      = x_q;
        y_d      = y_q;
        wsel_d   = wsel_q;
        filled_d = filled_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
        wren_d   = 4'b0000;
        meta_in  = '0;
        if (vs_rise) begin
            // vsync wins over a coincident pixel
            state_d  = StIdle;
            armed_d  = 1'b1;
            x_d      = '0;
            y_d      = '0;
            wsel_d   = 2'd0;
            filled_d = 2'd0;
            err_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle:  if (de && armed_q) state_d = StLine;
                StLine:  if (!de) state_d = StHblk;
                StHblk:  if (de) state_d = StLine;
                default: state_d = StIdle;
            endcase
            if (de && accept_en) begin
                armed_d = 1'b0;
                if (x_q < XMax) begin
                    wdata_d        = pix_data;
                    waddr_d        = x_q;
                    wren_d         = 4'b0001 << wsel_q;
                    x_d            = x_q + ADDR_W'(1);
                    meta_in.v      = col_ok;
                    meta_in.x      = x_q;
                    meta_in.y      = y_q;
                    meta_in.wsel   = wsel_q;
`ifdef LINEBUF_ZEROPAD_EN
                    meta_in.filled = filled_q;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end else if (!de && state_q == StLine) begin
                wsel_d   = wsel_q + 2'd1;
                x_d      = '0;
                y_d      = (y_q == 11'd2047) ? y_q : y_q + 11'd1;
                filled_d = (filled_q == 2'd3) ? filled_q : filled_q + 2'd1;
            end
        end
    end

    assign qv[0]    = bram.q0;
    assign qv[1]    = bram.q1;
    assign qv[2]    = bram.q2;
    assign qv[3]    = bram.q3;
    assign meta_out = meta_q[PIPE-1];

    // Banks after the write bank hold progressively newer lines.
    always_comb begin
        col_top_d   = col_top_q;
        col_mid_d   = col_mid_q;
        col_bot_d   = col_bot_q;
        col_x_d     = col_x_q;
        col_y_d     = col_y_q;
        col_valid_d = meta_out.v;
        if (meta_out.v) begin
            col_top_d = qv[meta_out.wsel + 2'd1];
            col_mid_d = qv[meta_out.wsel + 2'd2];
            col_bot_d = qv[meta_out.wsel + 2'd3];
`ifdef LINEBUF_ZEROPAD_EN
            if (meta_out.filled < 2'd3) col_top_d = '0;
            if (meta_out.filled < 2'd2) col_mid_d = '0;
            if (meta_out.filled < 2'd1) col_bot_d = '0;
`endif
            col_x_d = meta_out.x;
            col_y_d = meta_out.y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            vsync_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            wsel_q      <= 2'd0;
            filled_q    <= 2'd0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            wren_q      <= 4'b0000;
            for (int unsigned i = 0; i < PIPE; i++) meta_q[i] <= '0;
            col_top_q   <= '0;
            col_mid_q   <= '0;
            col_bot_q   <= '0;
            col_valid_q <= 1'b0;
            col_x_q     <= '0;
            col_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            vsync_q     <= vsync;
            x_q         <= x_d;
            y_q         <= y_d;
            wsel_q      <= wsel_d;
            filled_q    <= filled_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            wren_q      <= wren_d;
            meta_q[0]   <= meta_in;
            for (int unsigned i = 1; i < PIPE; i++) meta_q[i] <= meta_q[i-1];
            col_top_q   <= col_top_d;
            col_mid_q   <= col_mid_d;
            col_bot_q   <= col_bot_d;
            col_valid_q <= col_valid_d;
            col_x_q     <= col_x_d;
            col_y_q     <= col_y_d;
        end
    end

    assign bram.bram_datain = wdata_q;
    assign bram.bramaddr0   = waddr_q;
    assign bram.bramaddr1   = waddr_q;
    assign bram.bramaddr2   = waddr_q;
    assign bram.bramaddr3   = waddr_q;
    assign bram.wren0       = wren_q[0];
    assign bram.wren1       = wren_q[1];
    assign bram.wren2       = wren_q[2];
    assign bram.wren3       = wren_q[3];
    assign col_top          = col_top_q;
    assign col_mid          = col_mid_q;
    assign col_bot          = col_bot_q;
    assign col_valid        = col_valid_q;
    assign col_x            = col_x_q;
    assign col_y            = col_y_q;
    assign err_ovf          = err_q;
endmodule

// File: tb/tb_hdmi_linebuf_ctrl.sv
// Randomized scoreboard bench for hdmi_linebuf_ctrl with a line-level reference model
// and a two-cycle-latency BRAM model for the four banks.
module tb_hdmi_linebuf_ctrl;
    localparam int unsigned H_ACTIVE = 16;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned DATA_W   = 24;
    localparam int unsigned READ_LAT = 2;
    localparam int          COL_LAT  = READ_LAT + 2;
    localparam int          MEM_N    = 2048;
`ifdef LINEBUF_ZEROPAD_EN
    localparam bit ZEROPAD = 1'b1;
`else
    localparam bit ZEROPAD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              vsync = 1'b0;
    logic              de = 1'b0;
    logic [DATA_W-1:0] pix_data = '0;
    logic [DATA_W-1:0] col_top, col_mid, col_bot;
    logic              col_valid;
    logic [ADDR_W-1:0] col_x;
    logic [10:0]       col_y;
    logic              err_ovf;

    hdmi_linebuf_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    hdmi_linebuf_ctrl #(
        .H_ACTIVE(H_ACTIVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .de(de), .pix_data(pix_data), .bram(bus),
        .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot), .col_valid(col_valid),
        .col_x(col_x), .col_y(col_y), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: registered address, registered q.
    logic [DATA_W-1:0] mem [4][MEM_N];
    logic [ADDR_W-1:0] raddr [4];
    logic [DATA_W-1:0] q_r [4];
    logic [3:0]        wr;
    assign wr = {bus.wren3, bus.wren2, bus.wren1, bus.wren0};

    always @(posedge clk) begin
        if (bus.wren0) mem[0][bus.bramaddr0] <= bus.bram_datain;
        if (bus.wren1) mem[1][bus.bramaddr1] <= bus.bram_datain;
        if (bus.wren2) mem[2][bus.bramaddr2] <= bus.bram_datain;
        if (bus.wren3) mem[3][bus.bramaddr3] <= bus.bram_datain;
        raddr[0] <= bus.bramaddr0;
        raddr[1] <= bus.bramaddr1;
        raddr[2] <= bus.bramaddr2;
        raddr[3] <= bus.bramaddr3;
        for (int k = 0; k < 4; k++) q_r[k] <= mem[k][raddr[k]];
    end
    assign bus.q0 = q_r[0];
    assign bus.q1 = q_r[1];
    assign bus.q2 = q_r[2];
    assign bus.q3 = q_r[3];

    // Reference model state: banks hold lines of the frame, bank = line number mod 4.
    typedef struct {
        int                bank;
        int                x;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] old;
        int                cyc;
    } wr_t;
    typedef struct {
        logic [DATA_W-1:0] top;
        logic [DATA_W-1:0] mid;
        logic [DATA_W-1:0] bot;
        int                x;
        int                y;
        int                cyc;
    } col_t;

    logic [DATA_W-1:0] bm [4][MEM_N];
    wr_t  wq[$];
    col_t cq[$];
    int   m_x, m_y, m_line, m_filled;
    bit   m_armed, m_frame, m_inline, m_err, m_vsprev, err_vis;
    bit   mon_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_line = 0; m_filled = 0;
        m_armed = 0; m_frame = 0; m_inline = 0; m_err = 0; m_vsprev = 0; err_vis = 0;
    endtask

    task automatic model_step(input bit vs, input bit d, input logic [DATA_W-1:0] p);
        wr_t  w;
        col_t c;
        bit   rise;
        int   b;
        rise = vs && !m_vsprev;
        m_vsprev = vs;
        b = m_line % 4;
        if (rise) begin
            m_x = 0; m_y = 0; m_line = 0; m_filled = 0; m_err = 0;
            m_armed = 1; m_frame = 0; m_inline = 0;
        end else if (d && (m_armed || m_frame)) begin
            m_armed = 0; m_frame = 1; m_inline = 1;
            if (m_x < H_ACTIVE) begin
                w.bank = b; w.x = m_x; w.data = p; w.old = bm[b][m_x]; w.cyc = cyc + 1;
                wq.push_back(w);
                if (ZEROPAD || m_filled == 3) begin
                    c.top = (m_filled >= 3) ? bm[(b + 1) % 4][m_x] : '0;
                    c.mid = (m_filled >= 2) ? bm[(b + 2) % 4][m_x] : '0;
                    c.bot = (m_filled >= 1) ? bm[(b + 3) % 4][m_x] : '0;
                    c.x = m_x; c.y = m_y; c.cyc = cyc + COL_LAT;
                    cq.push_back(c);
                end
                bm[b][m_x] = p;
                m_x++;
            end else begin
                m_err = 1;
            end
        end else if (!d && m_inline) begin
            m_inline = 0;
            m_x = 0;
            m_line = (m_line + 1) % 4;
            if (m_y < 2047) m_y++;
            if (m_filled < 3) m_filled++;
        end
    endtask

    task automatic drive(input bit vs, input bit d, input logic [DATA_W-1:0] p);
        @(posedge clk);
        #1;
        vsync = vs; de = d; pix_data = p;
        err_vis = m_err;
        model_step(vs, d, p);
    endtask

    task automatic run_line(input int len, input int gap);
        for (int i = 0; i < len; i++) drive(1'b0, 1'b1, DATA_W'($urandom));
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic vsync_pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) drive(1'b1, 1'b0, '0);
        for (int i = 0; i < lo; i++) drive(1'b0, 1'b0, '0);
    endtask

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return H_ACTIVE;
        if (r < 9) return int'($urandom_range(1, H_ACTIVE - 1));
        return H_ACTIVE + int'($urandom_range(1, 3));
    endfunction

    task automatic check_reset_outputs(input string tag);
        logic any;
        any = |{bus.bram_datain, bus.bramaddr0, bus.bramaddr1, bus.bramaddr2, bus.bramaddr3,
                wr, col_top, col_mid, col_bot, col_valid, col_x, col_y, err_ovf};
        n_vec++;
        if (any !== 1'b0) begin
            n_err++;
            $display("FAIL %s: outputs wren=%b col_valid=%b err=%b datain=%h, required all zero",
                     tag, wr, col_valid, err_ovf, bus.bram_datain);
        end
    endtask

    wr_t  mw;
    col_t mc;
    always @(negedge clk) begin
        if (mon_en && reset) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                mw = wq.pop_front();
                n_vec++; n_err++;
                $display("FAIL write_missing: no write at cyc %0d, required bank %0d x=%0d data=%h",
                         mw.cyc, mw.bank, mw.x, mw.data);
            end
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
                mc = cq.pop_front();
                n_vec++; n_err++;
                $display("FAIL col_missing: no col_valid at cyc %0d, required x=%0d y=%0d",
                         mc.cyc, mc.x, mc.y);
            end
            if (wr != 4'b0000) begin
                n_vec++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: wren=%b addr=%0d at cyc %0d, required no write",
                             wr, bus.bramaddr0, cyc);
                end else begin
                    mw = wq.pop_front();
                    if (wr !== (4'b0001 << mw.bank) || bus.bram_datain !== mw.data ||
                        bus.bramaddr0 !== ADDR_W'(mw.x) || bus.bramaddr1 !== ADDR_W'(mw.x) ||
                        bus.bramaddr2 !== ADDR_W'(mw.x) || bus.bramaddr3 !== ADDR_W'(mw.x) ||
                        cyc != mw.cyc) begin
                        n_err++;
                        $display("FAIL write_check: wren=%b addr=%0d/%0d/%0d/%0d data=%h cyc=%0d, required wren=%b addr=%0d data=%h cyc=%0d",
                                 wr, bus.bramaddr0, bus.bramaddr1, bus.bramaddr2, bus.bramaddr3,
                                 bus.bram_datain, cyc, 4'b0001 << mw.bank, mw.x, mw.data, mw.cyc);
                    end
                end
            end
            if (col_valid) begin
                n_vec++;
                if (cq.size() == 0) begin
                    n_err++;
                    $display("FAIL col_unexpected: col_valid=1 x=%0d y=%0d at cyc %0d, required 0",
                             col_x, col_y, cyc);
                end else begin
                    mc = cq.pop_front();
                    if (col_top !== mc.top || col_mid !== mc.mid || col_bot !== mc.bot ||
                        col_x !== ADDR_W'(mc.x) || col_y !== 11'(mc.y) || cyc != mc.cyc) begin
                        n_err++;
                        $display("FAIL col_check: top=%h mid=%h bot=%h x=%0d y=%0d cyc=%0d, required top=%h mid=%h bot=%h x=%0d y=%0d cyc=%0d",
                                 col_top, col_mid, col_bot, col_x, col_y, cyc,
                                 mc.top, mc.mid, mc.bot, mc.x, mc.y, mc.cyc);
                    end
                end
            end
            n_vec++;
            if (err_ovf !== err_vis) begin
                n_err++;
                $display("FAIL err_ovf: got %b at cyc %0d, required %b", err_ovf, cyc, err_vis);
            end
        end
    end

    task automatic reset_mid_stream();
        @(posedge clk);
        #2;
        reset = 1'b0;
        mon_en = 1'b0;
        vsync = 1'b0; de = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        // Writes still in flight are lost, so the model banks roll back.
        for (int i = wq.size() - 1; i >= 0; i--) bm[wq[i].bank][wq[i].x] = wq[i].old;
        wq.delete();
        cq.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_reset_outputs("reset_hold");
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < MEM_N; i++) begin
                mem[k][i] = '0;
                bm[k][i]  = '0;
            end
            raddr[k] = '0;
            q_r[k]   = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_init");
        #2;
        reset = 1'b1;
        mon_en = 1'b1;

        run_line(5, 2);                       // ignored: no vsync yet
        vsync_pulse(2, 3);
        for (int l = 0; l < 6; l++) run_line(H_ACTIVE, 1 + int'($urandom_range(0, 2)));
        run_line(H_ACTIVE + 2, 2);            // overflow sets err_ovf
        run_line(H_ACTIVE, 2);

        // vsync rises while de is high at x=3
        vsync_pulse(1, 2);
        run_line(H_ACTIVE, 2);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, DATA_W'($urandom));
        drive(1'b1, 1'b1, DATA_W'($urandom));
        drive(1'b1, 1'b1, DATA_W'($urandom));
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, DATA_W'($urandom));
        drive(1'b0, 1'b0, '0);
        for (int l = 0; l < 4; l++) run_line(rand_len(), 1 + int'($urandom_range(0, 2)));

        repeat (4) begin
            vsync_pulse(1 + int'($urandom_range(0, 2)), 2);
            repeat (int'($urandom_range(4, 9))) run_line(rand_len(), 1 + int'($urandom_range(0, 3)));
        end

        vsync_pulse(2, 2);
        for (int l = 0; l < 5; l++) run_line(H_ACTIVE, 1);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, DATA_W'($urandom));
        reset_mid_stream();
        run_line(H_ACTIVE, 2);                // no writes before vsync
        run_line(7, 2);
        vsync_pulse(1, 2);
        repeat (7) run_line(rand_len(), 1 + int'($urandom_range(0, 2)));
        repeat (10) drive(1'b0, 1'b0, '0);

        n_vec++;
        if (wq.size() != 0 || cq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d writes and %0d columns outstanding, required 0 and 0",
                     wq.size(), cq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
